// File: rtl/reset_seq_gen_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// counter-width helpers.
package reset_seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } seq_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough to hold the larger of the two spacing counts without wrapping
  function automatic int unsigned cnt_width(input int unsigned stretch, input int unsigned step);
    return $clog2(max2(stretch, step) + 32'd1);
  endfunction

  function automatic int unsigned chan_width(input int unsigned n_out);
    return $clog2(n_out + 32'd1);
  endfunction

endpackage

// File: rtl/reset_seq_gen_sync.sv
// Negedge deassertion synchroniser: asynchronously cleared, shifts in ones
// after the async reset lifts and flags sync_ok once the chain is full.
module reset_seq_gen_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sync_ok
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_sync_ok = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq_gen.sv
// Reset sequencer: async assert, synchronised stretch, then per-channel
// release at fixed spacing; a sampled soft request restarts from the stretch.
module reset_seq_gen
  import reset_seq_gen_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 10,
  parameter int N_OUT          = 3,
  parameter int STEP_CYCLES    = 4
) (
  input  logic             clk,
  input  logic             reset_a_n,
  input  logic             sw_reset_req,
  output logic [N_OUT-1:0] reset_n,
  output logic             reset_done
);

  localparam int CW  = cnt_width(STRETCH_CYCLES, STEP_CYCLES);
  localparam int CHW = chan_width(N_OUT);
  localparam logic [CW-1:0]  STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0]  STEP_LAST    = CW'(STEP_CYCLES - 1);
  localparam logic [CHW-1:0] LAST_CHAN    = CHW'(N_OUT - 1);

  if (SYNC_STAGES < 2 || STRETCH_CYCLES < 1 || N_OUT < 1 || STEP_CYCLES < 1) begin : g_bad_param
    $fatal(1, "reset_seq_gen: illegal parameter value");
  end

  seq_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [CHW-1:0]   r_chan;
  logic [N_OUT-1:0] r_reset_n;
  logic             r_done;
  logic             w_sync_ok;
  logic [N_OUT-1:0] w_next_mask;

  reset_seq_gen_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk     (clk),
    .i_rst_n   (reset_a_n),
    .o_sync_ok (w_sync_ok)
  );

  // Channels release strictly in index order, so the next mask is a shift-in of one
  assign w_next_mask = (r_reset_n << 1) | N_OUT'(1);

  // The edge on which ASSERT first sees sync_ok counts as the first stretch edge
  always_ff @(negedge clk or negedge reset_a_n) begin
    if (!reset_a_n) begin
      r_state   <= ST_ASSERT;
      r_cnt     <= '0;
      r_chan    <= '0;
      r_reset_n <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_ASSERT, ST_STRETCH: begin
          if (r_state == ST_STRETCH && sw_reset_req) begin
            r_cnt     <= '0;
            r_chan    <= '0;
            r_reset_n <= '0;
            r_done    <= 1'b0;
          end else if (r_state == ST_STRETCH || w_sync_ok) begin
            if (r_cnt == STRETCH_LAST) begin
              r_cnt     <= '0;
              r_reset_n <= N_OUT'(1);
              if (N_OUT == 1) begin
                r_state <= ST_DONE;
                r_chan  <= '0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_RELEASE;
                r_chan  <= CHW'(1);
              end
            end else begin
              r_cnt   <= r_cnt + CW'(1);
              r_state <= ST_STRETCH;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_RELEASE: begin
          if (sw_reset_req) begin
            r_state   <= ST_STRETCH;
            r_cnt     <= '0;
            r_chan    <= '0;
            r_reset_n <= '0;
            r_done    <= 1'b0;
          end else if (r_cnt == STEP_LAST) begin
            r_cnt     <= '0;
            r_reset_n <= w_next_mask;
            if (r_chan == LAST_CHAN) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_chan <= r_chan + CHW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (sw_reset_req) begin
            r_state   <= ST_STRETCH;
            r_cnt     <= '0;
            r_chan    <= '0;
            r_reset_n <= '0;
            r_done    <= 1'b0;
          end else begin
            r_reset_n <= '1;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_ASSERT;
          r_cnt     <= '0;
          r_chan    <= '0;
          r_reset_n <= '0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  // Gating with the raw async input makes assertion immediate, clock or not
  assign reset_n    = r_reset_n & {N_OUT{reset_a_n}};
  assign reset_done = r_done & reset_a_n;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen: power-up, async override, soft requests
// and a single-channel short-stretch variant.
module tb_reset_seq_gen;

  logic       clk = 1'b0;
  logic       reset_a_n = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [2:0] reset_n;
  logic       reset_done;

  logic       rst6_n = 1'b0;
  logic       sw6 = 1'b0;
  logic [0:0] rn6;
  logic       done6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_seq_gen #(
    .SYNC_STAGES(2), .STRETCH_CYCLES(10), .N_OUT(3), .STEP_CYCLES(4)
  ) u_dut (
    .clk          (clk),
    .reset_a_n    (reset_a_n),
    .sw_reset_req (sw_reset_req),
    .reset_n      (reset_n),
    .reset_done   (reset_done)
  );

  reset_seq_gen #(
    .SYNC_STAGES(3), .STRETCH_CYCLES(1), .N_OUT(1), .STEP_CYCLES(4)
  ) u_dut6 (
    .clk          (clk),
    .reset_a_n    (rst6_n),
    .sw_reset_req (sw6),
    .reset_n      (rn6),
    .reset_done   (done6)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected mask k edges into a sequence whose bit 0 releases at edge first
  function automatic logic [2:0] exp_mask(input int k, input int first);
    if (k >= first + 8) return 3'b111;
    else if (k >= first + 4) return 3'b011;
    else if (k >= first) return 3'b001;
    else return 3'b000;
  endfunction

  // Assumes reset_a_n just rose between negedges; checks edges E1..E[last]
  task automatic run_powerup(input string tag, input int last, input int sw_edges);
    sw_reset_req = (sw_edges > 0);
    for (int e = 1; e <= last; e++) begin
      @(negedge clk);
      #1;
      sw_reset_req = (e < sw_edges);
      check_val($sformatf("%s_rn_E%0d", tag, e), 32'(reset_n), 32'(exp_mask(e, 12)));
      check_val($sformatf("%s_done_E%0d", tag, e), 32'(reset_done), (e >= 20) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #2;
    check_val("rst_rn", 32'(reset_n), 32'd0);
    check_val("rst_done", 32'(reset_done), 32'd0);
    check_val("rst6_rn", 32'(rn6), 32'd0);
    repeat (2) @(negedge clk);

    // Scenario 1: plain power-up
    @(posedge clk);
    reset_a_n = 1'b1;
    run_powerup("pwr", 21, 0);

    // Scenario 2: async reset mid-RELEASE, then a clean repeat
    reset_a_n = 1'b0;
    repeat (2) @(posedge clk);
    reset_a_n = 1'b1;
    run_powerup("pre2", 14, 0);
    #2;
    reset_a_n = 1'b0;
    #1;
    check_val("async_rn", 32'(reset_n), 32'd0);
    check_val("async_done", 32'(reset_done), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check_val("async_hold_rn", 32'(reset_n), 32'd0);
    @(posedge clk);
    reset_a_n = 1'b1;
    run_powerup("rep", 21, 0);

    // Scenario 3: one-edge soft request in DONE
    sw_reset_req = 1'b1;
    @(negedge clk);
    #1;
    sw_reset_req = 1'b0;
    check_val("sw1_S_rn", 32'(reset_n), 32'd0);
    check_val("sw1_S_done", 32'(reset_done), 32'd0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("sw1_rn_S%0d", k), 32'(reset_n), 32'(exp_mask(k, 10)));
      check_val($sformatf("sw1_done_S%0d", k), 32'(reset_done), (k >= 18) ? 32'd1 : 32'd0);
    end

    // Scenario 4: get into RELEASE, then hold the request for 5 edges
    sw_reset_req = 1'b1;
    @(negedge clk);
    #1;
    sw_reset_req = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    check_val("sw5_pre_rn", 32'(reset_n), 32'd1);
    for (int k = 0; k <= 22; k++) begin
      sw_reset_req = (k <= 4);
      @(negedge clk);
      #1;
      check_val($sformatf("sw5_rn_S%0d", k), 32'(reset_n), 32'(exp_mask(k, 14)));
      check_val($sformatf("sw5_done_S%0d", k), 32'(reset_done), (k >= 22) ? 32'd1 : 32'd0);
    end
    sw_reset_req = 1'b0;

    // Scenario 5: requests while in async reset and in ASSERT are ignored
    reset_a_n = 1'b0;
    #1;
    check_val("sw_async_rn", 32'(reset_n), 32'd0);
    sw_reset_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("sw_async_hold_rn", 32'(reset_n), 32'd0);
    sw_reset_req = 1'b0;
    @(posedge clk);
    reset_a_n = 1'b1;
    run_powerup("sw_ign", 21, 2);

    // Scenario 6: N_OUT=1, STRETCH=1, SYNC=3
    @(posedge clk);
    rst6_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      #1;
      check_val($sformatf("n1_rn_E%0d", e), 32'(rn6), (e >= 4) ? 32'd1 : 32'd0);
      check_val($sformatf("n1_done_E%0d", e), 32'(done6), (e >= 4) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
